// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - arm/trigger/readout sequencer for one oscilloscope acquisition
module capture_sequencer #(
    parameter int ADDR_W       = 8,
    parameter int AUTO_TIMEOUT = 1000000,
    parameter int HOLDOFF      = 1024
) (
    input  logic              clk_50mhz,
    input  logic              reset,
    input  logic              cmd_arm,
    input  logic              cmd_stop,
    input  logic [1:0]        mode,
    output logic              smp_activate,
    output logic              smp_force_trig,
    input  logic              smp_done,
    input  logic [ADDR_W-1:0] trig_offset,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic [2:0]        state_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int TCW   = (AUTO_TIMEOUT < 2) ? 1 : $clog2(AUTO_TIMEOUT + 1);
    localparam int HCW   = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

    localparam logic [TCW-1:0]    T_LAST   = TCW'(AUTO_TIMEOUT - 1);
    localparam logic [TCW-1:0]    T_CAP    = TCW'(AUTO_TIMEOUT);
    localparam logic [HCW-1:0]    H_LAST   = HCW'(HOLDOFF - 1);
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] HALF     = ADDR_W'(DEPTH / 2);
    localparam logic [1:0]        MODE_AUTO = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_WAIT   = 3'd2,
        S_READ   = 3'd3,
        S_STREAM = 3'd4,
        S_HOLD   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [TCW-1:0]    tcnt_q, tcnt_d;
    logic [HCW-1:0]    hcnt_q, hcnt_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              act_q, act_d;
    logic              force_q, force_d;
    logic              valid_q, valid_d;
    logic              first_q, first_d;
    logic [7:0]        hold_q, hold_d;

    logic auto_mode;
    logic single_mode;
    logic handshake;
    logic last_beat;

    assign auto_mode   = (mode_q == MODE_AUTO);
    assign single_mode = (mode_q[1] == mode_q[0]);
    assign handshake   = valid_q & out_ready;
    assign last_beat   = (count_q == LAST_CNT);

    // Next-state and datapath decisions; cmd_stop overrides everything else
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tcnt_d  = tcnt_q;
        hcnt_d  = hcnt_q;
        start_d = start_q;
        count_d = count_q;
        valid_d = valid_q;
        first_d = 1'b0;
        hold_d  = hold_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_arm) begin
                    mode_d  = mode;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Saturating one past the pulse value keeps the force pulse single
                if (auto_mode && (tcnt_q != T_CAP)) begin
                    tcnt_d = tcnt_q + TCW'(1);
                end
                if (smp_done) begin
                    start_d = trig_offset + HALF;
                    count_d = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                valid_d = 1'b1;
                first_d = 1'b1;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                // Memory data is live on the first cycle; keep a copy for stalls
                if (first_q) begin
                    hold_d = rd_data;
                end
                if (handshake) begin
                    valid_d = 1'b0;
                    count_d = count_q + (ADDR_W + 1)'(1);
                    if (last_beat) begin
                        hcnt_d = '0;
                        if (single_mode) begin
                            state_d = S_IDLE;
                        end else if (HOLDOFF == 0) begin
                            state_d = S_ARM;
                        end else begin
                            state_d = S_HOLD;
                        end
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_HOLD: begin
                if (hcnt_q == H_LAST) begin
                    state_d = S_ARM;
                end else begin
                    hcnt_d = hcnt_q + HCW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cmd_stop) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            first_d = 1'b0;
        end
    end

    // Registered sampler controls derived from where the FSM goes next
    always_comb begin
        act_d   = (state_d == S_ARM) || (state_d == S_WAIT);
        force_d = (state_d == S_WAIT) && auto_mode && (tcnt_d == T_LAST);
    end

    // State and datapath registers
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= 2'b00;
            tcnt_q  <= '0;
            hcnt_q  <= '0;
            start_q <= '0;
            count_q <= '0;
            act_q   <= 1'b0;
            force_q <= 1'b0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            hold_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            tcnt_q  <= tcnt_d;
            hcnt_q  <= hcnt_d;
            start_q <= start_d;
            count_q <= count_d;
            act_q   <= act_d;
            force_q <= force_d;
            valid_q <= valid_d;
            first_q <= first_d;
            hold_q  <= hold_d;
        end
    end

    assign rd_addr        = start_q + count_q[ADDR_W-1:0];
    assign out_data       = valid_q ? (first_q ? rd_data : hold_q) : 8'd0;
    assign out_valid      = valid_q;
    assign out_last       = valid_q & last_beat;
    assign smp_activate   = act_q;
    assign smp_force_trig = force_q;
    assign busy           = (state_q != S_IDLE);
    assign state_o        = state_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - randomized self-checking bench for capture_sequencer
module tb_capture_sequencer;

    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int AT    = 20;
    localparam int HO    = 5;

    logic          clk_50mhz   = 1'b0;
    logic          reset       = 1'b0;
    logic          cmd_arm     = 1'b0;
    logic          cmd_stop    = 1'b0;
    logic          smp_done    = 1'b0;
    logic          out_ready   = 1'b0;
    logic [1:0]    mode        = 2'b00;
    logic [AW-1:0] trig_offset = '0;
    logic [7:0]    rd_data     = 8'd0;
    logic          smp_activate, smp_force_trig, out_valid, out_last, busy;
    logic [AW-1:0] rd_addr;
    logic [7:0]    out_data;
    logic [2:0]    state_o;

    logic [7:0] mem [DEPTH];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    bit  rand_ready = 1'b0;
    int  n_bytes, n_last, n_force, n_hold, n_act, arm_cyc, force_cyc;
    int  addr_log[$];
    int  done_cyc, idle_cyc, off;

    // reference model: spec-level state, a queue of expected frame bytes, a force deadline
    int         m_st = 0;
    bit         m_single = 1'b1;
    bit         m_auto = 1'b0;
    int         m_force_at = -1;
    int         m_hold_left = 0;
    logic [7:0] q[$];

    capture_sequencer #(.ADDR_W(AW), .AUTO_TIMEOUT(AT), .HOLDOFF(HO)) dut (
        .clk_50mhz(clk_50mhz), .reset(reset), .cmd_arm(cmd_arm), .cmd_stop(cmd_stop),
        .mode(mode), .smp_activate(smp_activate), .smp_force_trig(smp_force_trig),
        .smp_done(smp_done), .trig_offset(trig_offset), .rd_addr(rd_addr),
        .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .state_o(state_o)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    always @(posedge clk_50mhz) cyc <= cyc + 1;

    always @(posedge clk_50mhz) rd_data <= mem[rd_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            m_st = 0; m_single = 1'b1; m_auto = 1'b0; m_force_at = -1; m_hold_left = 0;
            q.delete();
        end else if (cmd_stop) begin
            m_st = 0;
            q.delete();
        end else begin
            case (m_st)
                0: if (cmd_arm) begin
                    m_single = (mode == 2'b00) || (mode == 2'b11);
                    m_auto   = (mode == 2'b10);
                    m_st     = 1;
                end
                1: begin
                    m_st = 2;
                    m_force_at = m_auto ? cyc + AT : -1;
                end
                2: if (smp_done) begin
                    for (int i = 0; i < DEPTH; i++)
                        q.push_back(mem[(int'(trig_offset) + DEPTH / 2 + i) % DEPTH]);
                    m_st = 3;
                end
                3: m_st = 4;
                4: if (out_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_hold_left = HO;
                        m_st = m_single ? 0 : ((HO == 0) ? 1 : 5);
                    end else begin
                        m_st = 3;
                    end
                end
                5: begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_st = 1;
                end
                default: m_st = 0;
            endcase
        end
    end

    // compare process plus event statistics for the directed literal checks
    always @(negedge clk_50mhz) begin
        if (reset) begin
            check("state_o", 32'(state_o), 32'(m_st));
            check("busy", 32'(busy), 32'(m_st != 0));
            check("smp_activate", 32'(smp_activate), 32'(m_st == 1 || m_st == 2));
            check("smp_force_trig", 32'(smp_force_trig), 32'(m_st == 2 && cyc == m_force_at));
            check("out_valid", 32'(out_valid), 32'(m_st == 4));
            check("out_last", 32'(out_last), 32'(m_st == 4 && q.size() == 1));
            if (m_st == 4) check("out_data", 32'(out_data), 32'(q[0]));
            if (out_valid && out_ready) begin
                n_bytes++;
                addr_log.push_back(int'(out_data[3:0]));
                if (out_last) n_last++;
            end
            if (smp_force_trig) begin n_force++; force_cyc = cyc; end
            if (state_o == 3'd1) arm_cyc = cyc;
            if (state_o == 3'd5) n_hold++;
            if (smp_activate) n_act++;
        end
    end

    task automatic step();
        @(posedge clk_50mhz);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_stats();
        n_bytes = 0; n_last = 0; n_force = 0; n_hold = 0; n_act = 0;
        arm_cyc = 0; force_cyc = 0;
        addr_log.delete();
    endtask

    task automatic pulse_arm(input logic [1:0] m);
        mode = m; cmd_arm = 1'b1; step(); cmd_arm = 1'b0;
    endtask

    task automatic pulse_done(input logic [AW-1:0] o);
        trig_offset = o; smp_done = 1'b1; step(); smp_done = 1'b0;
    endtask

    task automatic pulse_stop();
        cmd_stop = 1'b1; step(); cmd_stop = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int limit, input string name);
        int i = 0;
        while (state_o !== s && i < limit) begin step(); i++; end
        check(name, 32'(state_o), 32'(s));
    endtask

    task automatic wait_bytes(input int k, input int limit, input string name);
        int i = 0;
        while (n_bytes < k && i < limit) begin step(); i++; end
        check(name, 32'(n_bytes >= k), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {4'($urandom_range(0, 15)), 4'(i)};
        clear_stats();

        repeat (3) @(posedge clk_50mhz);
        #1;
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_activate", 32'(smp_activate), 32'd0);
        check("rst_force", 32'(smp_force_trig), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        reset = 1'b1;
        step(); step();

        // single mode, trigger at 3, no backpressure
        clear_stats();
        out_ready = 1'b1;
        pulse_arm(2'b00);
        repeat (3) step();
        done_cyc = cyc;
        pulse_done(4'd3);
        wait_state(3'd0, 100, "single_end");
        idle_cyc = cyc;
        check("single_bytes", 32'(n_bytes), 32'd16);
        check("single_first_addr", 32'(addr_log[0]), 32'd11);
        check("single_wrap_addr", 32'(addr_log[5]), 32'd0);
        check("single_last_addr", 32'(addr_log[15]), 32'd10);
        check("single_last_cnt", 32'(n_last), 32'd1);
        check("single_act_cycles", 32'(n_act), 32'd4);
        check("single_frame_len", 32'(idle_cyc - done_cyc), 32'd33);
        check("single_force_cnt", 32'(n_force), 32'd0);
        check("single_busy_after", 32'(busy), 32'd0);

        // random backpressure, random offsets, stray commands while streaming
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            off = $urandom_range(0, DEPTH - 1);
            clear_stats();
            pulse_arm((f % 2 == 1) ? 2'b11 : 2'b00);
            repeat ($urandom_range(1, 6)) step();
            pulse_done(AW'(off));
            repeat (5) step();
            pulse_arm(2'b01);
            pulse_done(~AW'(off));
            wait_state(3'd0, 400, "bp_end");
            check("bp_bytes", 32'(n_bytes), 32'(DEPTH));
            check("bp_last", 32'(n_last), 32'd1);
            for (int i = 0; i < DEPTH; i++)
                check("bp_order", 32'(addr_log[i]), 32'((off + DEPTH / 2 + i) % DEPTH));
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        step();

        // auto mode: forced trigger, frame, holdoff, automatic re-arm
        clear_stats();
        pulse_arm(2'b10);
        repeat (30) step();
        check("auto_force_cnt", 32'(n_force), 32'd1);
        check("auto_force_delay", 32'(force_cyc - arm_cyc), 32'd20);
        pulse_done(AW'($urandom_range(0, DEPTH - 1)));
        wait_state(3'd1, 100, "auto_rearm");
        check("auto_bytes", 32'(n_bytes), 32'd16);
        check("auto_last", 32'(n_last), 32'd1);
        check("auto_hold", 32'(n_hold), 32'd5);
        pulse_stop();
        check("auto_stop_state", 32'(state_o), 32'd0);
        check("auto_stop_act", 32'(smp_activate), 32'd0);

        // normal mode: two frames separated by holdoff
        clear_stats();
        pulse_arm(2'b01);
        repeat (2) step();
        pulse_done(AW'($urandom_range(0, DEPTH - 1)));
        wait_state(3'd1, 100, "normal_rearm");
        check("normal_hold", 32'(n_hold), 32'd5);
        repeat (3) step();
        pulse_done(AW'($urandom_range(0, DEPTH - 1)));
        wait_bytes(32, 100, "normal_bytes");
        check("normal_last", 32'(n_last), 32'd2);
        check("normal_force", 32'(n_force), 32'd0);
        wait_state(3'd5, 10, "normal_hold2");
        pulse_stop();
        check("normal_stop_state", 32'(state_o), 32'd0);

        // stop in the middle of a frame
        clear_stats();
        pulse_arm(2'b00);
        step();
        pulse_done(AW'($urandom_range(0, DEPTH - 1)));
        wait_bytes(7, 60, "stop_bytes7");
        step();
        pulse_stop();
        check("stop_state", 32'(state_o), 32'd0);
        check("stop_valid", 32'(out_valid), 32'd0);
        check("stop_act", 32'(smp_activate), 32'd0);
        repeat (40) step();
        check("stop_no_last", 32'(n_last), 32'd0);
        check("stop_truncated", 32'(n_bytes <= 8), 32'd1);
        pulse_done(4'd5);
        step();
        check("stop_done_ignored", 32'(busy), 32'd0);

        // stop coincident with arm never leaves IDLE
        mode = 2'b00; cmd_arm = 1'b1; cmd_stop = 1'b1;
        step();
        cmd_arm = 1'b0; cmd_stop = 1'b0;
        check("coinc_state", 32'(state_o), 32'd0);
        repeat (3) step();
        check("coinc_busy", 32'(busy), 32'd0);

        // asynchronous reset between edges while waiting for the trigger
        clear_stats();
        pulse_arm(2'b00);
        repeat (3) step();
        #2 reset = 1'b0;
        #1;
        check("areset_state", 32'(state_o), 32'd0);
        check("areset_act", 32'(smp_activate), 32'd0);
        check("areset_busy", 32'(busy), 32'd0);
        check("areset_valid", 32'(out_valid), 32'd0);
        #3 reset = 1'b1;
        step();
        pulse_done(4'd2);
        repeat (5) step();
        check("areset_done_ignored", 32'(busy), 32'd0);
        clear_stats();
        pulse_arm(2'b00);
        step();
        pulse_done(AW'($urandom_range(0, DEPTH - 1)));
        wait_state(3'd0, 100, "areset_frame_end");
        check("areset_frame_bytes", 32'(n_bytes), 32'd16);
        check("areset_frame_last", 32'(n_last), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
